// File: rtl/spi_apb_regif.sv
// APB4 slave front-end for the SPI controller: register decode, one-cycle write/W1C
// strobes, TX push / RX pop with bounded wait states, registered prdata and pslverr.
module spi_apb_regif #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAIT_MAX   = 15
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    cr_wen,
    output logic                    br_wen,
    output logic                    ier_wen,
    output logic [DATA_WIDTH-1:0]   isr_w1c,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic [DATA_WIDTH-1:0]   cr_in,
    input  logic [DATA_WIDTH-1:0]   br_in,
    input  logic [DATA_WIDTH-1:0]   ier_in,
    input  logic [DATA_WIDTH-1:0]   sr_in,
    input  logic [DATA_WIDTH-1:0]   risr_in,
    input  logic [DATA_WIDTH-1:0]   isr_in,
    input  logic                    tx_full,
    output logic                    tx_wen,
    output logic [DATA_WIDTH-1:0]   tx_wdata,
    input  logic                    rx_empty,
    input  logic [DATA_WIDTH-1:0]   rx_rdata,
    output logic                    rx_ren
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [1:0] {StIdle, StAcc, StWait} state_e;

    state_e                 state_q, state_d;
    logic                   err_q, err_d;
    logic                   wr_q, wr_d;
    logic [2:0]             idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;

    logic                   setup;
    logic [2:0]             idx;
    logic                   dec_err;
    logic                   is_data;
    logic                   fifo_rdy;
    logic                   wait_rdy;
    logic                   fire;
    logic                   acc;
    logic [DATA_WIDTH-1:0]  rd_val;
    logic [DATA_WIDTH-1:0]  strb_mask;

    assign setup    = psel & ~penable;
    assign idx      = paddr[4:2];
    // Misaligned, out-of-map, read-only/reserved write, or partial DATA write
    assign dec_err  = (paddr[1:0] != 2'b00) | ((paddr >> 5) != '0)
                    | (pwrite & ((idx == 3'd3) | (idx == 3'd4) | (idx == 3'd6)))
                    | (pwrite & (idx == 3'd7) & (pstrb != {STRB_W{1'b1}}));
    assign is_data  = (idx == 3'd7) & ~dec_err;
    assign fifo_rdy = pwrite ? ~tx_full : ~rx_empty;
    assign wait_rdy = wr_q ? ~tx_full : ~rx_empty;

    // Read-back mux for register addresses
    always_comb begin
        rd_val = '0;
        case (idx)
            3'd0:    rd_val = cr_in;
            3'd1:    rd_val = br_in;
            3'd2:    rd_val = ier_in;
            3'd3:    rd_val = sr_in;
            3'd4:    rd_val = risr_in;
            3'd5:    rd_val = isr_in;
            3'd7:    rd_val = rx_rdata;
            default: rd_val = '0;
        endcase
    end

    // Byte-lane expansion of pstrb for the W1C mask
    always_comb begin
        strb_mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb_mask[8*i +: 8] = {8{pstrb[i]}};
        end
    end

    // Next-state logic: setup decode, FIFO wait with timeout
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        prdata_d = prdata_q;
        case (state_q)
            StIdle, StAcc: begin
                state_d = StIdle;
                err_d   = 1'b0;
                if (setup) begin
                    wr_d  = pwrite;
                    idx_d = idx;
                    cnt_d = '0;
                    if (dec_err) begin
                        state_d  = StAcc;
                        err_d    = 1'b1;
                        prdata_d = '0;
                    end else if (!is_data) begin
                        state_d  = StAcc;
                        prdata_d = pwrite ? '0 : rd_val;
                    end else if (fifo_rdy) begin
                        state_d  = StAcc;
                        prdata_d = pwrite ? '0 : rx_rdata;
                    end else if (WAIT_MAX == 0) begin
                        state_d  = StAcc;
                        err_d    = 1'b1;
                        prdata_d = '0;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!psel) begin
                    state_d = StIdle;
                end else if (wait_rdy) begin
                    state_d = StAcc;
                    if (!wr_q) prdata_d = rx_rdata;
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    state_d  = StAcc;
                    err_d    = 1'b1;
                    prdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q  <= StIdle;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
        end
    end

    // Access-phase outputs; every strobe is forced low while in reset
    always_comb begin
        acc     = preset_n & (state_q == StAcc);
        fire    = acc & psel & penable & ~err_q;
        pready  = acc;
        pslverr = acc & err_q;
        cr_wen  = fire & wr_q & (idx_q == 3'd0);
        br_wen  = fire & wr_q & (idx_q == 3'd1);
        ier_wen = fire & wr_q & (idx_q == 3'd2);
        isr_w1c = (fire & wr_q & (idx_q == 3'd5)) ? (pwdata & strb_mask) : '0;
        tx_wen  = fire & wr_q & (idx_q == 3'd7);
        rx_ren  = fire & ~wr_q & (idx_q == 3'd7);
    end

    assign prdata    = prdata_q;
    assign reg_wdata = pwdata;
    assign reg_wstrb = pstrb;
    assign tx_wdata  = pwdata;

endmodule

// File: tb/tb_spi_apb_regif.sv
// Randomized scoreboard bench for spi_apb_regif: the driver pushes the expected completion
// of each APB transfer; a negedge monitor pops and compares whenever pready is seen.
module tb_spi_apb_regif;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int WM = 15;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic        wr;
        logic [31:0] rdata;
        logic [31:0] waits;
        logic        cr;
        logic        br;
        logic        ier;
        logic        tx;
        logic        rx;
        logic [31:0] w1c;
        logic [3:0]  strb;
        logic [31:0] wd;
    } exp_t;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [SW-1:0] pstrb = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          cr_wen;
    logic          br_wen;
    logic          ier_wen;
    logic [DW-1:0] isr_w1c;
    logic [DW-1:0] reg_wdata;
    logic [SW-1:0] reg_wstrb;
    logic          tx_full = 1'b0;
    logic          tx_wen;
    logic [DW-1:0] tx_wdata;
    logic          rx_empty = 1'b0;
    logic [DW-1:0] rx_val = '0;
    logic          rx_ren;
    logic [DW-1:0] regv [6];

    int   checks = 0;
    int   failures = 0;
    int   wcnt = 0;
    exp_t q[$];
    exp_t mon_e;

    spi_apb_regif #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .WAIT_MAX  (WM)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .cr_wen   (cr_wen),
        .br_wen   (br_wen),
        .ier_wen  (ier_wen),
        .isr_w1c  (isr_w1c),
        .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb),
        .cr_in    (regv[0]),
        .br_in    (regv[1]),
        .ier_in   (regv[2]),
        .sr_in    (regv[3]),
        .risr_in  (regv[4]),
        .isr_in   (regv[5]),
        .tx_full  (tx_full),
        .tx_wen   (tx_wen),
        .tx_wdata (tx_wdata),
        .rx_empty (rx_empty),
        .rx_rdata (rx_val),
        .rx_ren   (rx_ren)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected completion of one transfer, from the register map rules.
    // k = WAIT cycle in which the FIFO becomes ready (0 = ready at setup).
    function automatic exp_t model(input logic wr, input logic [AW-1:0] addr,
                                   input logic [31:0] wd, input logic [3:0] st, input int k);
        exp_t        e;
        int          idx;
        logic [31:0] mask;
        e      = '0;
        e.wr   = wr;
        e.rd   = !wr;
        e.strb = st;
        e.wd   = wd;
        idx    = (int'(addr) % 32) / 4;
        e.err  = (int'(addr) % 4 != 0) || (int'(addr) >= 32)
              || (wr && (idx == 3 || idx == 4 || idx == 6))
              || (wr && idx == 7 && st != 4'hF);
        if (!e.err && idx == 7 && k != 0) begin
            if (k <= WM) e.waits = 32'(k);
            else begin
                e.waits = WM;
                e.err   = 1'b1;
            end
        end
        if (!wr && !e.err) begin
            if (idx < 6) e.rdata = regv[idx];
            else if (idx == 7) e.rdata = rx_val;
        end
        if (!e.err) begin
            mask = '0;
            for (int b = 0; b < 4; b++) if (st[b]) mask[8*b +: 8] = 8'hFF;
            e.cr  = wr && idx == 0;
            e.br  = wr && idx == 1;
            e.ier = wr && idx == 2;
            e.w1c = (wr && idx == 5) ? (wd & mask) : 32'h0;
            e.tx  = wr && idx == 7;
            e.rx  = !wr && idx == 7;
        end
        return e;
    endfunction

    // Monitor: compare on every completed access, otherwise require quiet strobes
    always @(negedge pclk) begin
        if (preset_n && psel && penable && pready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion: got pready=1 expected no transfer at %0t",
                         $time);
            end else begin
                mon_e = q.pop_front();
                chk("pslverr", 32'(pslverr), 32'(mon_e.err));
                chk("wait_cycles", 32'(wcnt), mon_e.waits);
                if (mon_e.rd) chk("prdata", prdata, mon_e.rdata);
                chk("cr_wen", 32'(cr_wen), 32'(mon_e.cr));
                chk("br_wen", 32'(br_wen), 32'(mon_e.br));
                chk("ier_wen", 32'(ier_wen), 32'(mon_e.ier));
                chk("isr_w1c", isr_w1c, mon_e.w1c);
                chk("tx_wen", 32'(tx_wen), 32'(mon_e.tx));
                chk("rx_ren", 32'(rx_ren), 32'(mon_e.rx));
                if (mon_e.wr) begin
                    chk("reg_wstrb", 32'(reg_wstrb), 32'(mon_e.strb));
                    chk("reg_wdata", reg_wdata, mon_e.wd);
                    chk("tx_wdata", tx_wdata, mon_e.wd);
                end
            end
            wcnt = 0;
        end else begin
            chk("strobes_idle", {26'h0, cr_wen, br_wen, ier_wen, tx_wen, rx_ren, |isr_w1c},
                32'h0);
            if (preset_n && psel && penable) wcnt++;
            else wcnt = 0;
        end
    end

    // One APB transfer; returns right after the completing edge so calls chain back-to-back
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int k);
        int i;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        pstrb   = st;
        tx_full  = 1'($urandom_range(0, 1));
        rx_empty = 1'($urandom_range(0, 1));
        if (wr) tx_full = (k != 0);
        else rx_empty = (k != 0);
        q.push_back(model(wr, addr, wd, st, k));
        @(posedge pclk);
        #1;
        i = 1;
        penable = 1'b1;
        if (i == k) begin
            tx_full  = 1'b0;
            rx_empty = 1'b0;
        end
        while (!pready && i < 40) begin
            @(posedge pclk);
            #1;
            i++;
            if (i == k) begin
                tx_full  = 1'b0;
                rx_empty = 1'b0;
            end
        end
        if (!pready) begin
            checks++;
            failures++;
            $display("FAIL transfer_timeout: got no pready expected completion within 40 cycles");
        end
        @(posedge pclk);
        #1;
        psel     = 1'b0;
        penable  = 1'b0;
        tx_full  = 1'b0;
        rx_empty = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        int            r;
        logic [3:0]    st;
        int            k;
        for (int i = 0; i < 6; i++) regv[i] = $urandom;

        // Reset state
        idle(3);
        chk("reset_pready", 32'(pready), 32'h0);
        preset_n = 1'b1;
        idle(1);
        chk("post_reset_prdata", prdata, 32'h0);
        chk("post_reset_pslverr", 32'(pslverr), 32'h0);
        chk("post_reset_pready", 32'(pready), 32'h0);

        // Directed cases
        xfer(1'b1, 8'h00, 32'h1234_5678, 4'b0011, 0);
        regv[3] = 32'h0000_00A5;
        xfer(1'b0, 8'h0C, 32'h0, 4'h0, 0);
        idle(1);
        rx_val = 32'hA5A5_0001;
        xfer(1'b0, 8'h1C, 32'h0, 4'h0, 3);
        xfer(1'b1, 8'h1C, 32'hDEAD_BEEF, 4'hF, 100);
        xfer(1'b0, 8'h02, 32'h0, 4'h0, 0);
        xfer(1'b1, 8'h0C, 32'h5555_AAAA, 4'hF, 0);
        xfer(1'b1, 8'h1C, 32'h0102_0304, 4'b0111, 0);
        idle(1);
        xfer(1'b1, 8'h14, 32'hFFFF_00F0, 4'b0001, 0);
        xfer(1'b1, 8'h00, 32'h0BAD_F00D, 4'hF, 0);
        xfer(1'b0, 8'h1C, 32'h0, 4'h0, WM);
        regv[0] = 32'hCAFE_0001;
        xfer(1'b0, 8'h00, 32'h0, 4'h0, 0);

        // Reset in the middle of a TX wait: no push, outputs return to reset values
        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = 1'b1;
        paddr    = 8'h1C;
        pstrb    = 4'hF;
        tx_full  = 1'b1;
        idle(1);
        penable  = 1'b1;
        idle(2);
        preset_n = 1'b0;
        idle(2);
        psel     = 1'b0;
        penable  = 1'b0;
        preset_n = 1'b1;
        idle(1);
        chk("midwait_reset_prdata", prdata, 32'h0);
        chk("midwait_reset_pslverr", 32'(pslverr), 32'h0);
        chk("midwait_reset_pready", 32'(pready), 32'h0);
        tx_full = 1'b0;
        idle(2);

        // Randomized traffic, back-to-back with occasional idle cycles
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 6; i++) regv[i] = $urandom;
            rx_val = $urandom;
            r = $urandom_range(0, 9);
            a = AW'($urandom_range(0, 7) * 4);
            if (r == 8) a = a | AW'($urandom_range(1, 3));
            else if (r == 9) a = a | AW'($urandom_range(1, 7) << 5);
            st = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            k  = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 18));
            xfer(1'($urandom_range(0, 1)), a, $urandom, st, k);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(3);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
